cpu_data_mem_responder: RTL and testbench

- Synthesizable responder for the memory end of the CPUtop data interface (data_address, data_out, data_R, data_W, data_in).
- Replaces the behavioural data memory in simulation and maps to BRAM in silicon.
- Zero-fills its storage after reset.
- Provides a host preload/readback port so a program's data image can be loaded before the CPU leaves reset.

---
 rtl/cpu_data_mem_responder.sv | 207 ++++++++++++++++++++
 tb/tb_cpu_data_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_data_mem_responder.sv
// ---------------------------------------------------------------------------
// cpu_data_mem_responder
//   Memory-side responder for the CPUtop data interface. It holds a single
//   word array (maps to block RAM) that is zero-filled by a one-word-per-cycle
//   sweep after reset. A host port allows a data image to be preloaded or
//   read back before the CPU runs.
//
// Parameters
//   ADDR_W  address width (CPUtop data_address)
//   DATA_W  word width (data_in / data_out)
//   DEPTH   implemented words (<= 2**ADDR_W); higher addresses are out of range
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   data_address/out/R/W     CPU request (R = access enable, W = write qualifier)
//   data_in                  CPU read data, one-cycle latency, held between reads
//   host_en/we/addr/wdata    host request; host wins over the CPU
//   host_rdata               host read data, held between host reads
//   ready                    clear sweep finished, accesses are serviced
//   addr_err                 one-cycle pulse after an out-of-range access
//   collision                sticky: a CPU access was dropped for the host
//
// Optional feature (macro MEM_ACCESS_STATS_EN)
//   rd_count / wr_count      saturating counts of completed CPU reads/writes
// ---------------------------------------------------------------------------
module cpu_data_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_R,
  input  logic              data_W,
  output logic [DATA_W-1:0] data_in,
  input  logic              host_en,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ready,
  output logic              addr_err,
`ifdef MEM_ACCESS_STATS_EN
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
`endif
  output logic              collision
);

  // Index width sized to the implemented array, not the full address space.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] data_in_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              addr_err_q;
  logic              collision_q;

  logic              in_ready_s;
  logic              host_act_s;
  logic              cpu_act_s;
  logic              host_ok_s;
  logic              cpu_ok_s;
  logic [IDX_W-1:0]  host_idx_s;
  logic [IDX_W-1:0]  cpu_idx_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // State register and clear pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next-state logic: sweep the array once, then stay in READY until reset.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = ST_READY;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + IDX_W'(1);
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Request decode: the host always wins, so the CPU is served only when the
  // host is idle. Range checks use one extra bit so DEPTH == 2**ADDR_W works.
  always_comb begin
    in_ready_s = (state_q == ST_READY);
    host_act_s = in_ready_s & host_en;
    cpu_act_s  = in_ready_s & data_R & ~host_en;
    host_ok_s  = ({1'b0, host_addr} < DEPTH_C);
    cpu_ok_s   = ({1'b0, data_address} < DEPTH_C);
    host_idx_s = host_addr[IDX_W-1:0];
    cpu_idx_s  = data_address[IDX_W-1:0];
  end

  // Single write port: sweep, else host write, else CPU write.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    if (state_q == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_ptr_q;
    end else if (host_act_s && host_we && host_ok_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = host_idx_s;
      mem_wdata_s = host_wdata;
    end else if (cpu_act_s && data_W && cpu_ok_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = cpu_idx_s;
      mem_wdata_s = data_out;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Storage array; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Registered read data and status. Reads sample the old word (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      data_in_q    <= '0;
      host_rdata_q <= '0;
      addr_err_q   <= 1'b0;
      collision_q  <= 1'b0;
    end else begin
      addr_err_q <= (host_act_s & ~host_ok_s) | (cpu_act_s & ~cpu_ok_s);
      if (host_act_s && !host_we) begin
        host_rdata_q <= host_ok_s ? mem_q[host_idx_s] : '0;
      end
      if (cpu_act_s && !data_W) begin
        data_in_q <= cpu_ok_s ? mem_q[cpu_idx_s] : '0;
      end
      if (in_ready_s && host_en && data_R) begin
        collision_q <= 1'b1;
      end
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;

  // Saturating counters of CPU accesses that actually reached the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      if (cpu_act_s && cpu_ok_s && !data_W && (rd_count_q != 32'hFFFF_FFFF)) begin
        rd_count_q <= rd_count_q + 32'd1;
      end
      if (cpu_act_s && cpu_ok_s && data_W && (wr_count_q != 32'hFFFF_FFFF)) begin
        wr_count_q <= wr_count_q + 32'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

  assign data_in    = data_in_q;
  assign host_rdata = host_rdata_q;
  assign addr_err   = addr_err_q;
  assign collision  = collision_q;
  assign ready      = (state_q == ST_READY);

endmodule

// File: tb/tb_cpu_data_mem_responder.sv
// ---------------------------------------------------------------------------
// Self-checking bench for cpu_data_mem_responder (DEPTH = 16, ADDR_W = 10 so
// out-of-range addresses 16..1023 are reachable). A reference model predicts
// every output for each driven cycle; the prediction is queued at drive time
// and popped when the cycle's outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_cpu_data_mem_responder;

  localparam int AW  = 10;
  localparam int DW  = 16;
  localparam int DEP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] data_address;
  logic [DW-1:0] data_out;
  logic          data_R;
  logic          data_W;
  logic [DW-1:0] data_in;
  logic          host_en;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          ready;
  logic          addr_err;
  logic          collision;
`ifdef MEM_ACCESS_STATS_EN
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;
`endif

  always #5 clk = ~clk;

  cpu_data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_address (data_address),
    .data_out     (data_out),
    .data_R       (data_R),
    .data_W       (data_W),
    .data_in      (data_in),
    .host_en      (host_en),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata),
    .ready        (ready),
    .addr_err     (addr_err),
`ifdef MEM_ACCESS_STATS_EN
    .rd_count     (rd_count),
    .wr_count     (wr_count),
`endif
    .collision    (collision)
  );

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] hrd;
    logic          err;
    logic          coll;
    logic [31:0]   rd;
    logic [31:0]   wr;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] m_mem [DEP];
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_hrd;
  logic          m_coll;
  logic [31:0]   m_rd;
  logic [31:0]   m_wr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) m_mem[i] = 16'h0000;
    m_din  = 16'h0000;
    m_hrd  = 16'h0000;
    m_coll = 1'b0;
    m_rd   = 32'd0;
    m_wr   = 32'd0;
  endtask

  task automatic idle_inputs();
    host_en      = 1'b0;
    host_we      = 1'b0;
    host_addr    = '0;
    host_wdata   = '0;
    data_R       = 1'b0;
    data_W       = 1'b0;
    data_address = '0;
    data_out     = '0;
  endtask

  // One serviced cycle: drive, predict, queue, then sample and compare.
  task automatic step(input logic he, input logic hw, input int ha, input logic [DW-1:0] hd,
                      input logic cr, input logic cw, input int ca, input logic [DW-1:0] cd,
                      input string tag);
    exp_t e;
    exp_t g;
    logic err;
    host_en      = he;
    host_we      = hw;
    host_addr    = ha[AW-1:0];
    host_wdata   = hd;
    data_R       = cr;
    data_W       = cw;
    data_address = ca[AW-1:0];
    data_out     = cd;
    err = 1'b0;
    if (he) begin
      if (!hw) m_hrd = (ha < DEP) ? m_mem[ha] : 16'h0000;
      if (ha >= DEP) err = 1'b1;
      if (cr) m_coll = 1'b1;
    end else if (cr) begin
      if (!cw) begin
        m_din = (ca < DEP) ? m_mem[ca] : 16'h0000;
        if (ca < DEP) m_rd = m_rd + 32'd1;
      end else if (ca < DEP) begin
        m_wr = m_wr + 32'd1;
      end
      if (ca >= DEP) err = 1'b1;
    end
    if (he && hw && (ha < DEP)) m_mem[ha] = hd;
    else if (!he && cr && cw && (ca < DEP)) m_mem[ca] = cd;
    e.din = m_din; e.hrd = m_hrd; e.err = err; e.coll = m_coll; e.rd = m_rd; e.wr = m_wr;
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    check_val({tag, ".data_in"}, data_in, g.din);
    check_val({tag, ".host_rdata"}, host_rdata, g.hrd);
    check_val({tag, ".addr_err"}, addr_err, g.err);
    check_val({tag, ".collision"}, collision, g.coll);
    check_val({tag, ".ready"}, ready, 1'b1);
`ifdef MEM_ACCESS_STATS_EN
    check_val({tag, ".rd_count"}, rd_count, g.rd);
    check_val({tag, ".wr_count"}, wr_count, g.wr);
`endif
  endtask

  task automatic do_reset(input int cycles, input string tag);
    rst = 1'b1;
    idle_inputs();
    repeat (cycles) @(negedge clk);
    check_val({tag, ".rst_data_in"}, data_in, 16'h0000);
    check_val({tag, ".rst_host_rdata"}, host_rdata, 16'h0000);
    check_val({tag, ".rst_ready"}, ready, 1'b0);
    check_val({tag, ".rst_addr_err"}, addr_err, 1'b0);
    check_val({tag, ".rst_collision"}, collision, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  // Expect ready low for DEP-1 cycles after reset release and high at DEP.
  // With inject set, requests are driven mid-sweep and must be ignored.
  task automatic sweep_check(input logic inject, input string tag);
    for (int i = 1; i <= DEP; i++) begin
      if (inject && (i == 10)) begin
        host_en = 1'b1; host_we = 1'b1; host_addr = 10'd3; host_wdata = 16'hBEEF;
        data_R = 1'b1; data_W = 1'b0; data_address = 10'd1;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      check_val($sformatf("%s.ready_c%0d", tag, i), ready, (i == DEP) ? 1'b1 : 1'b0);
    end
    check_val({tag, ".sweep_data_in"}, data_in, 16'h0000);
    check_val({tag, ".sweep_collision"}, collision, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();

    // Reset and full clear sweep, with ignored requests during the sweep.
    do_reset(2, "rst0");
    sweep_check(1'b1, "sweep0");
    step(1'b1, 1'b0, 7, 16'h0, 1'b0, 1'b0, 0, 16'h0, "hrd7");
    step(1'b1, 1'b0, 3, 16'h0, 1'b0, 1'b0, 0, 16'h0, "hrd3_ignored");

    // Host preload, CPU readback and hold.
    step(1'b1, 1'b1, 0, 16'd5,  1'b0, 1'b0, 0, 16'h0, "hwr0");
    step(1'b1, 1'b1, 1, 16'd15, 1'b0, 1'b0, 0, 16'h0, "hwr1");
    step(1'b1, 1'b1, 2, 16'd4,  1'b0, 1'b0, 0, 16'h0, "hwr2");
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 1'b0, 1, 16'h0, "crd1");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b1, 2, 16'h0, "hold");

    // CPU write then read.
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 1'b1, 0, 16'd20, "cwr0");
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 1'b0, 0, 16'h0, "crd0");

    // Host read racing a CPU write: host wins, old word returned, write dropped.
    step(1'b1, 1'b0, 0, 16'h0, 1'b1, 1'b1, 0, 16'd21, "race0");
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 1'b0, 0, 16'h0, "crd0_after");

    // Collision on writes to the same address; host data survives.
    step(1'b1, 1'b1, 3, 16'd7, 1'b1, 1'b1, 3, 16'd9, "coll3");
    step(1'b1, 1'b0, 3, 16'h0, 1'b0, 1'b0, 0, 16'h0, "hrd3");
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 1'b0, 3, 16'h0, "crd3");

    // Top in-range word.
    step(1'b1, 1'b1, 15, 16'h7777, 1'b0, 1'b0, 0, 16'h0, "hwr15");
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 1'b0, 15, 16'h0, "crd15");

    // Out-of-range accesses.
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 1'b1, 16, 16'hABCD, "cwr16");
    step(1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0, 0, 16'h0, "idle_err");
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 1'b0, 16, 16'h0, "crd16");
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 1'b0, 0, 16'h0, "crd0_nowrap");
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 1'b0, 1000, 16'h0, "crd1000");
    step(1'b1, 1'b1, 1023, 16'h1111, 1'b0, 1'b0, 0, 16'h0, "hwr1023");
    step(1'b1, 1'b0, 1023, 16'h0, 1'b0, 1'b0, 0, 16'h0, "hrd1023");
    step(1'b1, 1'b0, 20, 16'h0, 1'b1, 1'b0, 30, 16'h0, "both_oor");

    // Random traffic against the model.
    for (int k = 0; k < 40; k++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 20)),
           16'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 20)), 16'($urandom), "rand");
    end

    // Reset in READY, then again mid-sweep; the sweep restarts from zero.
    do_reset(1, "rst1");
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check_val($sformatf("mid.ready_c%0d", i), ready, 1'b0);
    end
    do_reset(1, "rst2");
    sweep_check(1'b0, "sweep2");
    step(1'b1, 1'b0, 0, 16'h0, 1'b0, 1'b0, 0, 16'h0, "hrd0_cleared");
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 1'b0, 15, 16'h0, "crd15_cleared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
